// File: rtl/dest_vc_buffer_pkg.sv
// Shared word format and backpressure constants for the arbiter and the
// destination VC buffer.
package dest_vc_buffer_pkg;
  localparam int DATA_WIDTH    = 5;
  localparam int VC_SEL_BIT    = 4;
  localparam int NUM_LANES     = 2;
  localparam int NUM_VCS       = 2;
  localparam int LANE0         = 0;
  localparam int LANE1         = 1;
  localparam int VC0           = 0;
  localparam int VC1           = 1;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_AF_MARGIN = 1;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
  } laneWord_t;
endpackage

// File: rtl/dest_vc_buffer_fifo.sv
// First-word-fall-through circular FIFO with overflow/underflow strobes and a
// look-ahead almost-full flag computed from the post-update count.
module sync_fifo #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] popData,
  output logic                  empty,
  output logic                  full,
  output logic                  almostFullNext,
  output logic                  ovf,
  output logic                  unf
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rdPtr, wrPtr;
  logic [AW:0]           count, countNext;
  logic                  doPush, doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop & ~empty;
  // a pop on a full FIFO frees the slot the push lands in
  assign doPush = push & (~full | doPop);
  assign ovf    = push & ~doPush;
  assign unf    = pop & empty;

  always_comb begin
    countNext = count;
    if (doPush && !doPop)      countNext = count + (AW+1)'(1);
    else if (doPop && !doPush) countNext = count - (AW+1)'(1);
  end

  assign almostFullNext = (countNext >= (AW+1)'(DEPTH - AF_MARGIN));
  assign popData        = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= countNext;
    end
  end

  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= pushData;
endmodule

// File: rtl/dest_vc_buffer.sv
// Receive side of the arbitration stage: steers each lane word into one of two
// VC FIFOs by its select bit, and returns per-lane pause plus a sticky error.
module dest_vc_buffer
  import dest_vc_buffer_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn0,
  input  logic [DATA_WIDTH-1:0] dataIn1,
  input  logic [1:0]            validBitsIn,
  input  logic                  popVC0_p0,
  input  logic                  popVC1_p0,
  input  logic                  popVC0_p1,
  input  logic                  popVC1_p1,
  output logic [DATA_WIDTH-1:0] dataVC0_p0,
  output logic [DATA_WIDTH-1:0] dataVC1_p0,
  output logic [DATA_WIDTH-1:0] dataVC0_p1,
  output logic [DATA_WIDTH-1:0] dataVC1_p1,
  output logic                  emptyVC0_p0,
  output logic                  emptyVC1_p0,
  output logic                  emptyVC0_p1,
  output logic                  emptyVC1_p1,
  output logic [1:0]            pause,
  output logic                  error
);
  laneWord_t [NUM_LANES-1:0]                           lane;
  logic [NUM_LANES-1:0][NUM_VCS-1:0]                   push, pop, empty, full, afNext, ovf, unf;
  logic [NUM_LANES-1:0][NUM_VCS-1:0][DATA_WIDTH-1:0]   head;
  logic [NUM_LANES-1:0]                                pauseQ;
  logic                                                errQ;
  logic                                                unusedFull;

  assign lane[LANE0] = '{vld: validBitsIn[LANE0], data: dataIn0};
  assign lane[LANE1] = '{vld: validBitsIn[LANE1], data: dataIn1};

  assign pop[LANE0][VC0] = popVC0_p0;
  assign pop[LANE0][VC1] = popVC1_p0;
  assign pop[LANE1][VC0] = popVC0_p1;
  assign pop[LANE1][VC1] = popVC1_p1;

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    for (genvar v = 0; v < NUM_VCS; v++) begin : gVc
      assign push[l][v] = lane[l].vld && (lane[l].data[VC_SEL_BIT] == 1'(v));
      sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) uFifo (
        .clk           (clk),
        .reset         (reset),
        .push          (push[l][v]),
        .pushData      (lane[l].data),
        .pop           (pop[l][v]),
        .popData       (head[l][v]),
        .empty         (empty[l][v]),
        .full          (full[l][v]),
        .almostFullNext(afNext[l][v]),
        .ovf           (ovf[l][v]),
        .unf           (unf[l][v])
      );
    end
  end

  assign unusedFull = ^full;

  always_ff @(posedge clk) begin
    if (reset) begin
      pauseQ <= '0;
      errQ   <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) pauseQ[l] <= |afNext[l];
      errQ <= errQ | (|ovf) | (|unf);
    end
  end

  assign pause       = pauseQ;
  assign error       = errQ;
  assign dataVC0_p0  = head[LANE0][VC0];
  assign dataVC1_p0  = head[LANE0][VC1];
  assign dataVC0_p1  = head[LANE1][VC0];
  assign dataVC1_p1  = head[LANE1][VC1];
  assign emptyVC0_p0 = empty[LANE0][VC0];
  assign emptyVC1_p0 = empty[LANE0][VC1];
  assign emptyVC0_p1 = empty[LANE1][VC0];
  assign emptyVC1_p1 = empty[LANE1][VC1];
endmodule

// File: tb/tb_dest_vc_buffer.sv
// Directed bench for dest_vc_buffer with DEPTH=4, AF_MARGIN=1.
module tb_dest_vc_buffer;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] dataIn0, dataIn1;
  logic [1:0] validBitsIn;
  logic       popVC0_p0, popVC1_p0, popVC0_p1, popVC1_p1;
  logic [4:0] dataVC0_p0, dataVC1_p0, dataVC0_p1, dataVC1_p1;
  logic       emptyVC0_p0, emptyVC1_p0, emptyVC0_p1, emptyVC1_p1;
  logic [1:0] pause;
  logic       error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dest_vc_buffer #(.DEPTH(4), .AF_MARGIN(1)) dut (
    .clk(clk), .reset(reset),
    .dataIn0(dataIn0), .dataIn1(dataIn1), .validBitsIn(validBitsIn),
    .popVC0_p0(popVC0_p0), .popVC1_p0(popVC1_p0), .popVC0_p1(popVC0_p1), .popVC1_p1(popVC1_p1),
    .dataVC0_p0(dataVC0_p0), .dataVC1_p0(dataVC1_p0), .dataVC0_p1(dataVC0_p1), .dataVC1_p1(dataVC1_p1),
    .emptyVC0_p0(emptyVC0_p0), .emptyVC1_p0(emptyVC1_p0), .emptyVC0_p1(emptyVC0_p1), .emptyVC1_p1(emptyVC1_p1),
    .pause(pause), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    validBitsIn = 2'b00;
    popVC0_p0 = 0; popVC1_p0 = 0; popVC0_p1 = 0; popVC1_p1 = 0;
  endtask

  task automatic wr0(input logic [4:0] d);
    validBitsIn = 2'b01;
    dataIn0 = d;
  endtask

  task automatic allEmpty(input string tag);
    chk({tag, "_empties"}, {28'd0, emptyVC0_p0, emptyVC1_p0, emptyVC0_p1, emptyVC1_p1}, 32'hF);
    chk({tag, "_datas"}, {12'd0, dataVC0_p0, dataVC1_p0, dataVC0_p1, dataVC1_p1}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; dataIn0 = '0; dataIn1 = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    allEmpty("reset");
    chk("reset_pause", pause, 2'b00);
    chk("reset_error", error, 1'b0);
    tick();
    allEmpty("idle");

    // steering: both lanes in the same edge
    validBitsIn = 2'b11; dataIn0 = 5'b00001; dataIn1 = 5'b10010;
    tick(); idle();
    chk("steer_e00", emptyVC0_p0, 1'b0);
    chk("steer_d00", dataVC0_p0, 5'b00001);
    chk("steer_e11", emptyVC1_p1, 1'b0);
    chk("steer_d11", dataVC1_p1, 5'b10010);
    chk("steer_e10", emptyVC1_p0, 1'b1);
    chk("steer_e01", emptyVC0_p1, 1'b1);
    popVC0_p0 = 1; popVC1_p1 = 1;
    tick(); idle();
    allEmpty("steer_clear");
    chk("steer_err", error, 1'b0);

    // fill lane 0 VC0 and watch pause
    wr0(5'b01011); tick(); chk("fill1_pause", pause, 2'b00);
    wr0(5'b01100); tick(); chk("fill2_pause", pause, 2'b00);
    wr0(5'b01101); tick(); chk("fill3_pause", pause, 2'b01);
    wr0(5'b01110); tick(); chk("fill4_err", error, 1'b0);
    wr0(5'b01111); tick(); idle();
    chk("ovf_err", error, 1'b1);
    chk("ovf_head", dataVC0_p0, 5'b01011);

    // drain in order
    popVC0_p0 = 1;
    tick(); chk("drain1", dataVC0_p0, 5'b01100); chk("drain1_pause", pause, 2'b01);
    tick(); chk("drain2", dataVC0_p0, 5'b01101); chk("drain2_pause", pause, 2'b00);
    tick(); chk("drain3", dataVC0_p0, 5'b01110);
    tick(); idle();
    chk("drain4_empty", emptyVC0_p0, 1'b1);
    chk("drain4_data", dataVC0_p0, 5'b00000);

    // refill across pointer wrap with interleaved pops
    wr0(5'h01); tick(); chk("wrap1", dataVC0_p0, 5'h01);
    wr0(5'h02); tick(); chk("wrap2", dataVC0_p0, 5'h01);
    wr0(5'h03); popVC0_p0 = 1; tick(); popVC0_p0 = 0; chk("wrap3", dataVC0_p0, 5'h02);
    wr0(5'h04); tick(); chk("wrap4_pause", pause, 2'b01);
    wr0(5'h05); popVC0_p0 = 1; tick(); chk("wrap5", dataVC0_p0, 5'h03);
    wr0(5'h06); tick(); idle(); chk("wrap6", dataVC0_p0, 5'h04);
    popVC0_p0 = 1;
    tick(); chk("wrapd1", dataVC0_p0, 5'h05);
    tick(); chk("wrapd2", dataVC0_p0, 5'h06);
    tick(); idle(); chk("wrapd3_empty", emptyVC0_p0, 1'b1);

    // push+pop on a full FIFO, starting from a clean error flag
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_err", error, 1'b0);
    wr0(5'b01011); tick();
    wr0(5'b01100); tick();
    wr0(5'b01101); tick();
    wr0(5'b01110); tick();
    wr0(5'b00111); popVC0_p0 = 1; tick(); idle();
    chk("fullpp_head", dataVC0_p0, 5'b01100);
    chk("fullpp_err", error, 1'b0);
    chk("fullpp_pause", pause, 2'b01);
    popVC0_p0 = 1;
    tick(); chk("fullpp_d1", dataVC0_p0, 5'b01101);
    tick(); chk("fullpp_d2", dataVC0_p0, 5'b01110);
    tick(); chk("fullpp_d3", dataVC0_p0, 5'b00111);
    tick(); idle(); chk("fullpp_empty", emptyVC0_p0, 1'b1);
    chk("fullpp_err2", error, 1'b0);

    // underflow on an empty FIFO
    popVC1_p0 = 1; tick(); idle();
    chk("unf_err", error, 1'b1);
    chk("unf_empty", emptyVC1_p0, 1'b1);
    chk("unf_data", dataVC1_p0, 5'b00000);
    wr0(5'b10101); tick(); idle();
    chk("unf_after_push", dataVC1_p0, 5'b10101);
    popVC1_p0 = 1; tick(); idle();
    chk("unf_after_pop", emptyVC1_p0, 1'b1);

    // push and pop together on an empty FIFO: push wins
    wr0(5'b00011); popVC0_p0 = 1; tick(); idle();
    chk("emptypp_empty", emptyVC0_p0, 1'b0);
    chk("emptypp_data", dataVC0_p0, 5'b00011);
    popVC0_p0 = 1; tick(); idle();

    // reset in the middle of traffic
    validBitsIn = 2'b10;
    dataIn1 = 5'b11000; tick();
    dataIn1 = 5'b11001; tick();
    dataIn1 = 5'b11010; tick();
    chk("mid_pause", pause, 2'b10);
    chk("mid_head", dataVC1_p1, 5'b11000);
    dataIn1 = 5'b11111; reset = 1'b1;
    tick(); reset = 1'b0; idle();
    allEmpty("mid_rst");
    chk("mid_rst_pause", pause, 2'b00);
    chk("mid_rst_err", error, 1'b0);
    tick();
    chk("mid_rst_nostore", emptyVC1_p1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
